// File: rtl/alu_pkg.sv
// Shared definitions for the 5-bit ALU and the round-robin scheduler that feeds it.
package alu_pkg;

   localparam int DATA_W = 5;
   localparam int OP_W   = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_AND = 3'b011,
      OP_OR  = 3'b100
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } sched_state_e;

   // Codes above OP_OR have no ALU function and are flagged as errors.
   function automatic logic isIllegalOp(input logic [OP_W-1:0] op);
      return (op > OP_OR);
   endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the client blocks and the ALU scheduler.
interface alu_rr_scheduler_if import alu_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) ();

   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_ready;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
   logic [NUM_REQ-1:0][OP_W-1:0]   req_op;
   logic                           rsp_valid;
   logic                           rsp_ready;
   logic [ID_W-1:0]                rsp_id;
   logic [DATA_W-1:0]              rsp_result;
   logic                           rsp_err;
   logic                           busy;

   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err, busy
   );

endinterface

// File: rtl/alu_rr_scheduler_alu.sv
// Combinational 5-bit ALU; every result wraps modulo 32, unknown opcodes give zero.
module ALU_5bit import alu_pkg::*; (
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [OP_W-1:0]   op_i,
   output logic [DATA_W-1:0] y_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_MUL:  y_o = a_i * b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU_5bit among NUM_REQ requesters,
// one operation in flight at a time (IDLE -> EXEC -> RESP).
module alu_rr_scheduler import alu_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_rr_scheduler_if.slave bus
);

   sched_state_e      state_q, state_d;
   logic [ID_W-1:0]   rrPtr_q, rrPtr_d;
   logic [DATA_W-1:0] opA_q, opB_q, result_q;
   logic [OP_W-1:0]   opCode_q;
   logic [ID_W-1:0]   id_q;
   logic              err_q;
   logic [ID_W-1:0]   grantIdx;
   logic [ID_W-1:0]   scanIdx;
   logic              grantFound;
   logic              accept;
   logic [DATA_W-1:0] aluY;

   // First valid requester at or after rrPtr_q, wrapping modulo NUM_REQ.
   always_comb begin
      grantFound = 1'b0;
      grantIdx   = '0;
      scanIdx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scanIdx = ID_W'((int'(rrPtr_q) + k) % NUM_REQ);
         if (!grantFound && bus.req_valid[scanIdx]) begin
            grantFound = 1'b1;
            grantIdx   = scanIdx;
         end
      end
   end

   assign accept = (state_q == S_IDLE) && grantFound && rst_n;

   always_comb begin
      bus.req_ready = '0;
      if (accept) begin
         bus.req_ready[grantIdx] = 1'b1;
      end
   end

   always_comb begin
      rrPtr_d = rrPtr_q;
      if (accept) begin
         rrPtr_d = ID_W'((int'(grantIdx) + 1) % NUM_REQ);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_EXEC;
         S_EXEC:  state_d = S_RESP;
         S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rrPtr_q <= '0;
      end else begin
         state_q <= state_d;
         rrPtr_q <= rrPtr_d;
      end
   end

   // The ALU only ever sees the captured operands, never the live request bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opA_q    <= '0;
         opB_q    <= '0;
         opCode_q <= '0;
         id_q     <= '0;
         result_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            opA_q    <= bus.req_a[grantIdx];
            opB_q    <= bus.req_b[grantIdx];
            opCode_q <= bus.req_op[grantIdx];
            id_q     <= grantIdx;
         end
         if (state_q == S_EXEC) begin
            result_q <= aluY;
            err_q    <= isIllegalOp(opCode_q);
         end
      end
   end

   ALU_5bit uAlu (
      .a_i  (opA_q),
      .b_i  (opB_q),
      .op_i (opCode_q),
      .y_o  (aluY)
   );

   assign bus.rsp_valid  = (state_q == S_RESP);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.rsp_id     = id_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: stimulus pushes expected responses into a
// scoreboard queue, a negedge monitor pops and compares on every response handshake.
module tb_alu_rr_scheduler;
   import alu_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] res;
      logic              err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cycleCnt = 0;
   int   lastCyc = 0;
   exp_t sbQ[$];
   exp_t monExp;
   logic [NUM_REQ-1:0] pendQ = '0;
   logic [ID_W-1:0]    seq[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   alu_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

   alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt++;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge clk) begin
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRsp: got id %0d result %0d, expected no response",
                     bus.rsp_id, bus.rsp_result);
         end else begin
            monExp = sbQ.pop_front();
            checkOutput("rspId", 32'(bus.rsp_id), 32'(monExp.id));
            checkOutput("rspResult", 32'(bus.rsp_result), 32'(monExp.res));
            checkOutput("rspErr", 32'(bus.rsp_err), 32'(monExp.err));
         end
      end
   end

   // Requesters must hold req_valid until granted.
   always @(posedge clk) begin
      if (!rst_n) begin
         pendQ = '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (pendQ[i] && !bus.req_valid[i]) begin
               errors++;
               $display("[TB] FAIL protocol: req %0d dropped valid, expected held", i);
            end
         end
         pendQ = bus.req_valid & ~bus.req_ready;
      end
   end

   task automatic waitGrant(input logic [ID_W-1:0] id);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.req_ready[id] && n < 50) begin
         n++;
         @(negedge clk);
      end
      checkOutput("grant", 32'(bus.req_ready), 32'd1 << id);
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      @(negedge clk);
      while ((bus.busy || bus.rsp_valid) && n < 50) begin
         n++;
         @(negedge clk);
      end
      checkOutput("idle", 32'(bus.busy), 32'd0);
   endtask

   task automatic setPayload(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] a,
                             input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op);
      bus.req_a[id]  = a;
      bus.req_b[id]  = b;
      bus.req_op[id] = op;
   endtask

   task automatic applyStimulus(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] b, input logic [OP_W-1:0] op,
                                input logic [DATA_W-1:0] expRes, input logic expErr);
      @(posedge clk);
      #1;
      setPayload(id, a, b, op);
      bus.req_valid[id] = 1'b1;
      sbQ.push_back('{id, expRes, expErr});
      waitGrant(id);
      @(posedge clk);
      #1;
      bus.req_valid[id] = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_op    = '0;
      bus.rsp_ready = 1'b1;
      bus.req_valid[2] = 1'b1;
      #12;
      checkOutput("resetRspValid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("resetRspId", 32'(bus.rsp_id), 32'd0);
      checkOutput("resetResult", 32'(bus.rsp_result), 32'd0);
      checkOutput("resetErr", 32'(bus.rsp_err), 32'd0);
      checkOutput("resetBusy", 32'(bus.busy), 32'd0);
      checkOutput("resetReqReady", 32'(bus.req_ready), 32'd0);
      bus.req_valid = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Single add with latency checks: 13 + 22 = 35 -> 3.
      @(posedge clk);
      #1;
      setPayload(2'd2, 5'd13, 5'd22, OP_ADD);
      bus.req_valid[2] = 1'b1;
      sbQ.push_back('{2'd2, 5'd3, 1'b0});
      @(negedge clk);
      checkOutput("singleReady", 32'(bus.req_ready), 32'd4);
      @(posedge clk);
      #1 bus.req_valid[2] = 1'b0;
      @(negedge clk);
      checkOutput("execRspValid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("execBusy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      checkOutput("latencyRspValid", 32'(bus.rsp_valid), 32'd1);
      @(negedge clk);
      checkOutput("backIdleBusy", 32'(bus.busy), 32'd0);
      checkOutput("backIdleRspValid", 32'(bus.rsp_valid), 32'd0);

      // Wrap-around arithmetic.
      applyStimulus(2'd1, 5'd3, 5'd5, OP_SUB, 5'd30, 1'b0);
      waitIdle();
      applyStimulus(2'd3, 5'd7, 5'd6, OP_MUL, 5'd10, 1'b0);
      waitIdle();
      applyStimulus(2'd0, 5'b10110, 5'b01111, OP_AND, 5'b00110, 1'b0);
      waitIdle();

      // Illegal opcode followed by a legal one.
      applyStimulus(2'd2, 5'd31, 5'd31, 3'b110, 5'd0, 1'b1);
      waitIdle();
      applyStimulus(2'd2, 5'd1, 5'd1, OP_ADD, 5'd2, 1'b0);
      waitIdle();

      // Backpressure: response 0 held while requester 1 waits.
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      applyStimulus(2'd0, 5'd5, 5'd10, OP_OR, 5'd15, 1'b0);
      setPayload(2'd1, 5'd9, 5'd12, OP_AND);
      bus.req_valid[1] = 1'b1;
      sbQ.push_back('{2'd1, 5'd8, 1'b0});
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         checkOutput("bpRspValid", 32'(bus.rsp_valid), 32'd1);
         checkOutput("bpRspId", 32'(bus.rsp_id), 32'd0);
         checkOutput("bpResult", 32'(bus.rsp_result), 32'd15);
         checkOutput("bpErr", 32'(bus.rsp_err), 32'd0);
         checkOutput("bpReqReady", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("bpReleaseReqReady", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      checkOutput("bpGrantAfter", 32'(bus.req_ready), 32'd2);
      @(posedge clk);
      #1 bus.req_valid[1] = 1'b0;
      waitIdle();

      // Contention from reset: grants 0,1,2,3,0, three cycles apart.
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      setPayload(2'd0, 5'd1, 5'd2, OP_ADD);
      setPayload(2'd1, 5'd10, 5'd4, OP_SUB);
      setPayload(2'd2, 5'd3, 5'd4, OP_MUL);
      setPayload(2'd3, 5'd12, 5'd3, OP_OR);
      bus.req_valid = 4'b1111;
      sbQ.push_back('{2'd0, 5'd3, 1'b0});
      sbQ.push_back('{2'd1, 5'd6, 1'b0});
      sbQ.push_back('{2'd2, 5'd12, 1'b0});
      sbQ.push_back('{2'd3, 5'd15, 1'b0});
      for (int g = 0; g < 5; g++) begin
         waitGrant(seq[g]);
         if (g > 0) checkOutput("grantGap", 32'(cycleCnt - lastCyc), 32'd3);
         lastCyc = cycleCnt;
         @(posedge clk);
         #1;
         if (g == 0) begin
            setPayload(2'd0, 5'd20, 5'd20, OP_ADD);
            sbQ.push_back('{2'd0, 5'd8, 1'b0});
         end else begin
            bus.req_valid[seq[g]] = 1'b0;
         end
      end
      waitIdle();

      // Reset during EXEC aborts the operation and clears the pointer.
      @(posedge clk);
      #1;
      setPayload(2'd2, 5'd1, 5'd1, OP_ADD);
      bus.req_valid[2] = 1'b1;
      waitGrant(2'd2);
      @(posedge clk);
      #1 bus.req_valid[2] = 1'b0;
      #1 rst_n = 1'b0;
      setPayload(2'd1, 5'd16, 5'd1, OP_OR);
      setPayload(2'd3, 5'd31, 5'd31, OP_MUL);
      bus.req_valid[1] = 1'b1;
      bus.req_valid[3] = 1'b1;
      sbQ.push_back('{2'd1, 5'd17, 1'b0});
      sbQ.push_back('{2'd3, 5'd1, 1'b0});
      #1;
      checkOutput("abortRspValid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("abortBusy", 32'(bus.busy), 32'd0);
      checkOutput("abortRspId", 32'(bus.rsp_id), 32'd0);
      checkOutput("abortResult", 32'(bus.rsp_result), 32'd0);
      checkOutput("abortReqReady", 32'(bus.req_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("postResetRspValid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("postResetBusy", 32'(bus.busy), 32'd0);
      checkOutput("postResetGrant", 32'(bus.req_ready), 32'd2);
      @(posedge clk);
      #1 bus.req_valid[1] = 1'b0;
      waitGrant(2'd3);
      @(posedge clk);
      #1 bus.req_valid[3] = 1'b0;
      waitIdle();

      repeat (3) @(negedge clk);
      checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_rr_scheduler.md
# alu_rr_scheduler

Round-robin scheduler that shares one 5-bit ALU datapath among `NUM_REQ` requesters. It accepts one operation at a time over a valid/ready handshake, registers the operands, and drives the shared ALU from those registers. It returns the registered result with the winning requester's ID on a single response channel. It sits between the client blocks and the shared ALU instance, and is the only block that drives the ALU inputs.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester ID.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — reset, asynchronous and active-low.
- `req_valid`  in  NUM_REQ  — per-requester operation request.
- `req_ready`  out  NUM_REQ  — per-requester grant/accept; at most one bit set.
- `req_a`  in  NUM_REQ×5  — operand A, one per requester.
- `req_b`  in  NUM_REQ×5  — operand B, one per requester.
- `req_op`  in  NUM_REQ×3  — opcode, one per requester.
- `rsp_valid`  out  1  — response available.
- `rsp_ready`  in  1  — response consumer accepts.
- `rsp_id`  out  ID_W  — index of the requester that issued the operation.
- `rsp_result`  out  5  — ALU result.
- `rsp_err`  out  1  — opcode was illegal (3'b101..3'b111).
- `busy`  out  1  — high in any state other than IDLE.

## Operation
- FSM states and transitions:
  - IDLE → EXEC on a request handshake (`req_valid[i] & req_ready[i]`).
  - EXEC → RESP unconditionally.
  - RESP → IDLE on `rsp_valid & rsp_ready`.
- Only one operation is in flight at a time. `req_ready` is all-zero outside IDLE.
- Arbitration, in IDLE:
  - Scan from `rr_ptr` upward, modulo NUM_REQ. The first `i` with `req_valid[i]` gets `req_ready[i]=1`.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and the state.
  - On a handshake with `i`, `rr_ptr` becomes `(i+1) mod NUM_REQ`. Otherwise `rr_ptr` holds.
- On a handshake, capture `req_a[i]`, `req_b[i]`, `req_op[i]` and `i` into operand/ID registers.
- In EXEC, the ALU inputs come only from the operand registers. The ALU output is captured into `rsp_result`, and `rsp_err` is set at the same edge.
- Opcode map:
  - 000 add, 001 sub, 010 mul, 011 AND, 100 OR.
  - Other codes give result 5'b00000 and `rsp_err=1`.
- Arithmetic: all results are truncated to 5 bits (mod 32). Subtraction wraps in two's complement; multiplication keeps the low 5 bits of the product. No carry or overflow is reported.
- In RESP, `rsp_valid=1`. `rsp_id`, `rsp_result` and `rsp_err` hold stable until the response handshake.
- Requester rules: once `req_valid` is asserted, the requester holds it and its payload stable until `req_ready`. Dropping `req_valid` early is a protocol violation (bench assertion).
- Reset values (async, on `rst_n` low):
  - State IDLE, `rr_ptr=0`.
  - `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_err=0`, `busy=0`.
  - `req_ready` is all-zero while `rst_n` is low.
- Reset mid-operation aborts the operation. No response is ever produced for it, and the requester must re-issue.

## Timing
- Request accepted at edge T0. EXEC occupies cycle T0→T1 and the result is registered at T1. `rsp_valid` is high from T1 on.
- Accept-to-response latency is 2 cycles.
- If `rsp_ready` is high at T1, the response handshake completes at edge T2 and the FSM is back in IDLE after T2.
- Peak throughput: one operation per 3 cycles.
- Backpressure: `rsp_valid` stays high indefinitely while `rsp_ready=0`. All requesters are stalled meanwhile.
- If requests arrive while the FSM is not in IDLE, they wait. On return to IDLE, arbitration uses the already-updated `rr_ptr`, so starvation is bounded to NUM_REQ−1 operations.

## Structure
- Shared package `alu_pkg` holds:
  - `DATA_W=5` and `OP_W=3`.
  - The opcode enum (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_AND`, `OP_OR`).
  - The scheduler state enum (`S_IDLE`, `S_EXEC`, `S_RESP`).
- One sub-module: the existing combinational `ALU_5bit`, instantiated once and fed from the operand registers.
- Round-robin arbitration stays inline in the scheduler.
- `rsp_err` is derived locally from the opcode register, not from the ALU.

## Test plan
- Single add: requester 2 sends a=13, b=22, op=000 → `req_ready[2]` in the same cycle; 2 cycles later `rsp_valid=1`, `rsp_id=2`, `rsp_result=3`, `rsp_err=0`.
- Wrap cases:
  - sub 3−5 → `rsp_result=30`.
  - mul 7×6 → `rsp_result=10`.
  - AND 5'b10110 with 5'b01111 → 5'b00110.
- Contention: all four `req_valid` high from reset with distinct operands → grants in order 0,1,2,3,0. `rsp_id` follows the same sequence; each grant is 3 cycles apart with `rsp_ready` tied high.
- Illegal opcode: op=3'b110, a=31, b=31 → `rsp_result=0`, `rsp_err=1`. The next legal op has `rsp_err=0`.
- Backpressure: hold `rsp_ready=0` for 10 cycles with requester 1 pending → `rsp_valid` held, fields stable, `req_ready` all-zero; on release, requester 1 is granted the cycle after the response handshake.
- Reset mid-EXEC: deassert `rst_n` one cycle after acceptance → outputs reset immediately and no `rsp_valid` appears after reset release. The first grant afterwards goes to the lowest valid requester (`rr_ptr=0`).
